// File: rtl/mult_issue_ctl.sv
// mult_issue_ctl: sequencer wrapped around the 32-bit shift-add multiplier.
// It accepts one operand pair at a time and turns signed operands into
// magnitudes. It pulses mult_start, then waits for a qualified mult_done.
// When the product arrives it applies the sign correction and holds the
// 64-bit result until the consumer takes it. Only one operation is in flight.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake; in_ready is high only in IDLE
//   in_a, in_b              32-bit operands
//   in_signed, in_tag       operand signedness and the request tag
//   mult_start              one-cycle start pulse to the multiplier
//   mult_a, mult_b          operand magnitudes, stable from START through LAG
//   mult_done, mult_product completion and product from the multiplier
//   out_valid/out_ready     result handshake; out_valid is high in HOLD
//   out_product, out_tag    sign-corrected product and the tag of that request
//   out_err                 timeout abort; out_product is 0 when this is set
//   busy                    the sequencer is not idle
module mult_issue_ctl #(
    parameter int TAG_W    = 4,
    parameter int PROD_LAG = 1,
    parameter int GUARD    = 2,
    parameter int TIMEOUT  = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mult_start,
    output logic [31:0]      mult_a,
    output logic [31:0]      mult_b,
    input  logic             mult_done,
    input  logic [63:0]      mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LAG   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // The wait counter saturates at CNT_MAX. With the timeout disabled,
    // the counter cannot wrap back under GUARD.
    localparam int CNT_MAX  = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int CNT_W    = $clog2(CNT_MAX + 2);
    localparam int LAG_LAST = (PROD_LAG > 0) ? PROD_LAG - 1 : 0;
    localparam int LAG_W    = $clog2(LAG_LAST + 2);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [LAG_W-1:0]   lag_cnt_r;
    logic               neg_r;
    logic               accept_s;
    logic               capture_s;
    logic               timeout_s;
    logic               done_qual_s;
    logic               timeout_hit_s;

    // Magnitude of a 32-bit operand. -2^31 maps to 32'h8000_0000 unsigned.
    function automatic logic [31:0] magnitude32(input logic [31:0] v, input logic sgn);
        magnitude32 = (sgn & v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negation of the 64-bit product.
    function automatic logic [63:0] negate64(input logic [63:0] v);
        negate64 = ~v + 64'd1;
    endfunction

    assign in_ready      = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign mult_start    = (state_r == ST_START);
    assign out_valid     = (state_r == ST_HOLD);
    // A done seen during the guard window is stale, left over from an earlier operation.
    assign done_qual_s   = mult_done && (wait_cnt_r >= CNT_W'(GUARD));
    assign timeout_hit_s = (TIMEOUT != 0) && (wait_cnt_r == CNT_W'(TIMEOUT));

    // Next-state and datapath-enable decode
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_qual_s) begin
                    if (PROD_LAG == 0) begin
                        capture_s    = 1'b1;
                        next_state_s = ST_HOLD;
                    end else begin
                        next_state_s = ST_LAG;
                    end
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_LAG: begin
                if (lag_cnt_r == LAG_W'(LAG_LAST)) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_LAG;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, counters, operand latch and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= '0;
            lag_cnt_r   <= '0;
            neg_r       <= 1'b0;
            mult_a      <= 32'd0;
            mult_b      <= 32'd0;
            out_product <= 64'd0;
            out_tag     <= '0;
            out_err     <= 1'b0;
        end else begin
            state_r <= next_state_s;

            if (accept_s) begin
                neg_r   <= in_signed & (in_a[31] ^ in_b[31]);
                mult_a  <= magnitude32(in_a, in_signed);
                mult_b  <= magnitude32(in_b, in_signed);
                out_tag <= in_tag;
            end

            if (state_r == ST_WAIT) begin
                if (wait_cnt_r != CNT_W'(CNT_MAX)) begin
                    wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                end
            end else begin
                wait_cnt_r <= '0;
            end

            if (state_r == ST_LAG) begin
                lag_cnt_r <= lag_cnt_r + LAG_W'(1);
            end else begin
                lag_cnt_r <= '0;
            end

            if (capture_s) begin
                out_product <= neg_r ? negate64(mult_product) : mult_product;
                out_err     <= 1'b0;
            end else if (timeout_s) begin
                out_product <= 64'd0;
                out_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_issue_ctl.sv
// Testbench for mult_issue_ctl. A behavioural multiplier responds to
// mult_start. It drives mult_done after a programmable delay. The product
// becomes valid one cycle after done; before that the product bus carries a
// garbage pattern. Expected values are hand-computed in the vector table.
module tb_mult_issue_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = 4'd0;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_done;
    logic [63:0] mult_product;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_product;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Multiplier model controls
    int   done_delay = 3;
    bit   done_en = 1'b1;
    logic stuck_done = 1'b0;
    logic model_done;
    bit   model_act;
    int   model_cnt;

    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

    always #5 clk = ~clk;

    mult_issue_ctl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag), .out_err(out_err),
        .busy(busy)
    );

    assign mult_done = model_done | stuck_done;

    // Behavioural multiplier: done after done_delay, product one cycle after done
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_done   <= 1'b0;
            model_act    <= 1'b0;
            model_cnt    <= 0;
            mult_product <= GARBAGE;
        end else begin
            model_done <= 1'b0;
            if (model_done) begin
                mult_product <= {32'd0, mult_a} * {32'd0, mult_b};
            end
            if (mult_start) begin
                model_act    <= 1'b1;
                model_cnt    <= done_delay;
                mult_product <= GARBAGE;
            end else if (model_act && done_en) begin
                if (model_cnt == 0) begin
                    model_done <= 1'b1;
                    model_act  <= 1'b0;
                end else begin
                    model_cnt <= model_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One request through the full sequence; hold = cycles with out_ready low
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [3:0] tag,
                          input logic [31:0] ema, input logic [31:0] emb,
                          input logic [63:0] eprod, input logic eerr, input int hold);
        int starts;
        int waited;
        out_ready = (hold == 0);
        @(negedge clk);
        chk({nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0; in_a = 32'h5A5A_5A5A; in_b = 32'hA5A5_A5A5; in_tag = ~tag;
        chk({nm, "_start"}, 64'(mult_start), 64'd1);
        chk({nm, "_mult_a"}, 64'(mult_a), 64'(ema));
        chk({nm, "_mult_b"}, 64'(mult_b), 64'(emb));
        starts = 1;
        waited = 0;
        while (!out_valid && waited < 300) begin
            @(negedge clk);
            if (mult_start) starts++;
            waited++;
        end
        chk({nm, "_out_valid_seen"}, 64'(out_valid), 64'd1);
        chk({nm, "_start_pulses"}, 64'(starts), 64'd1);
        chk({nm, "_product"}, out_product, eprod);
        chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
        chk({nm, "_err"}, 64'(out_err), 64'(eerr));
        chk({nm, "_in_ready_hold"}, 64'(in_ready), 64'd0);
        // Offer a competing request during backpressure and in the handshake cycle
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk({nm, "_bp_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_bp_product"}, out_product, eprod);
            chk({nm, "_bp_tag"}, 64'(out_tag), 64'(tag));
            chk({nm, "_bp_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_released_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_released_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [3:0]  tag;
        logic [31:0] ema;
        logic [31:0] emb;
        logic [63:0] eprod;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int waited;
        vecs[0] = '{32'd3,          32'd5,          1'b0, 4'h2, 32'd3,          32'd5,          64'd15,                  0};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 4'h3, 32'd3,          32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 0};
        vecs[2] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 4'h4, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 4'h5, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 10};
        vecs[4] = '{32'hFFFF_FFF9,  32'hFFFF_FFFA,  1'b1, 4'h6, 32'd7,          32'd6,          64'd42,                  0};
        vecs[5] = '{32'd0,          32'hFFFF_FFFB,  1'b1, 4'h7, 32'd0,          32'd5,          64'd0,                   0};
        vecs[6] = '{32'd100,        32'hFFFF_FFFF,  1'b1, 4'h8, 32'd100,        32'd1,          64'hFFFF_FFFF_FFFF_FF9C, 2};
        vecs[7] = '{32'hFFFF_FFFD,  32'd2,          1'b0, 4'hA, 32'hFFFF_FFFD,  32'd2,          64'h0000_0001_FFFF_FFFA, 0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mult_start", 64'(mult_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].tag,
                   vecs[i].ema, vecs[i].emb, vecs[i].eprod, 1'b0, vecs[i].hold);
        end

        // Done held high through START and the guard window, then dropped
        done_delay = 6;
        stuck_done = 1'b1;
        fork
            begin
                waited = 0;
                do begin
                    @(negedge clk);
                    waited++;
                end while (!mult_start && waited < 50);
                repeat (3) @(negedge clk);
                stuck_done = 1'b0;
            end
        join_none
        run_op("stuck", 32'd11, 32'd13, 1'b0, 4'hB, 32'd11, 32'd13, 64'd143, 1'b0, 0);
        stuck_done = 1'b0;
        done_delay = 3;

        // Done never arrives: timeout abort
        done_en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd9; in_signed = 1'b0; in_tag = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("to_start", 64'(mult_start), 64'd1);
        waited = 0;
        while (!out_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("to_valid", 64'(out_valid), 64'd1);
        chk("to_window", 64'((waited >= 80) && (waited <= 83)), 64'd1);
        chk("to_err", 64'(out_err), 64'd1);
        chk("to_product", out_product, 64'd0);
        chk("to_tag", 64'(out_tag), 64'h9);
        out_ready = 1'b1;
        @(negedge clk);
        chk("to_released", 64'(out_valid), 64'd0);

        // Reset asserted mid-WAIT: abort without a result
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2; in_tag = 4'h1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_start", 64'(mult_start), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        done_en = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        // Recovery after reset
        run_op("recover", 32'hFFFF_FFFE, 32'd4, 1'b1, 4'hC, 32'd2, 32'd4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
